// File: rtl/ip_exp2int_pkg.sv
// ip_exp2int_pkg: default widths shared by the antilog block and its interface
package ip_exp2int_pkg;
    localparam int DEF_IDWID = 5;
    localparam int DEF_FWID  = 4;
    localparam int DEF_ODWID = 16;
endpackage

// File: rtl/ip_exp2int_if.sv
// ip_exp2int_if: start/operand and result signals of the antilog calculator
interface ip_exp2int_if
    import ip_exp2int_pkg::*;
#(
    parameter int IDWID = DEF_IDWID,
    parameter int FWID  = DEF_FWID,
    parameter int ODWID = DEF_ODWID
);
    logic             i_cal_str;
    logic [IDWID-1:0] i_val;
    logic [FWID-1:0]  i_frac;
    logic [ODWID-1:0] o_val;
    logic             o_val_vld;
    logic             o_val_upd;
    logic             o_ovf;
    modport master (output i_cal_str, i_val, i_frac, input o_val, o_val_vld, o_val_upd, o_ovf);
    modport slave  (input i_cal_str, i_val, i_frac, output o_val, o_val_vld, o_val_upd, o_ovf);
endinterface

// File: rtl/ip_exp2int.sv
// ip_exp2int: floor((1 + F/2^FWID) * 2^E) by shifting one bit per cycle, saturating
// to all-ones when the result exceeds ODWID bits.
module ip_exp2int
    import ip_exp2int_pkg::*;
#(
    parameter int IDWID = DEF_IDWID,
    parameter int FWID  = DEF_FWID,
    parameter int ODWID = DEF_ODWID
) (
    input logic         clk,
    input logic         rst_n,
    ip_exp2int_if.slave bus
);
    localparam int AWID = ODWID + FWID;
    logic [AWID-1:0]  acc_q, acc_d;
    logic [IDWID-1:0] cnt_q, cnt_d;
    logic [ODWID-1:0] val_q, val_d;
    logic             act_q, act_d, vld_q, vld_d, upd_q, upd_d, ovf_q, ovf_d;
    logic             ovf_det, done;
    always_comb begin
        ovf_det = (cnt_q != '0) & acc_q[AWID-1];
        done    = act_q & ((cnt_q == '0) | ovf_det);
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        act_d   = act_q;
        vld_d   = vld_q;
        upd_d   = 1'b0;
        ovf_d   = ovf_q;
        // a new start always wins, silently dropping any calculation in flight
        if (bus.i_cal_str) begin
            acc_d = AWID'({1'b1, bus.i_frac});
            cnt_d = bus.i_val;
            act_d = 1'b1;
            vld_d = 1'b0;
        end else if (done) begin
            act_d = 1'b0;
            upd_d = 1'b1;
            vld_d = 1'b1;
            ovf_d = ovf_det;
            val_d = ovf_det ? '1 : acc_q[AWID-1:FWID];
        end else if (act_q) begin
            acc_d = acc_q << 1;
            cnt_d = cnt_q - 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            val_q <= '0;
            act_q <= 1'b0;
            vld_q <= 1'b0;
            upd_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            val_q <= val_d;
            act_q <= act_d;
            vld_q <= vld_d;
            upd_q <= upd_d;
            ovf_q <= ovf_d;
        end
    end
    assign bus.o_val     = val_q;
    assign bus.o_val_vld = vld_q;
    assign bus.o_val_upd = upd_q;
    assign bus.o_ovf     = ovf_q;
endmodule

// File: tb/tb_ip_exp2int.sv
// tb_ip_exp2int: directed and randomized checks of the antilog calculator against
// an arithmetic model of floor((2^FW + F) * 2^E / 2^FW) with saturation.
module tb_ip_exp2int;
    localparam int IDW = 5;
    localparam int FW  = 4;
    localparam int OW  = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    ip_exp2int_if #(.IDWID(IDW), .FWID(FW), .ODWID(OW)) bus ();
    ip_exp2int #(.IDWID(IDW), .FWID(FW), .ODWID(OW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    function automatic void model(input int e, input int f, output int lat,
                                  output logic [OW-1:0] v, output logic o);
        longint r;
        r   = (longint'((1 << FW) + f) << e) >> FW;
        o   = r >= (longint'(1) << OW);
        v   = o ? '1 : OW'(r);
        lat = (e >= OW) ? OW + 1 : e + 2;
    endfunction

    // leaves the bench 1ns into cycle 1 after the start cycle, operands scrambled
    task automatic start(input int e, input int f);
        @(negedge clk);
        bus.i_cal_str = 1'b1;
        bus.i_val     = IDW'(e);
        bus.i_frac    = FW'(f);
        @(posedge clk);
        #1;
        bus.i_cal_str = 1'b0;
        bus.i_val     = IDW'($urandom);
        bus.i_frac    = FW'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input int lat, input logic [OW-1:0] ev, input logic eo, input string nm);
        bit bad = 0;
        for (int c = 1; c < lat; c++) begin
            if (bus.o_val_upd !== 1'b0 || bus.o_val_vld !== 1'b0) bad = 1;
            step();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s: upd or vld high before cycle %0d", nm, lat);
        end
        checks++;
        if (bus.o_val_upd !== 1'b1 || bus.o_val !== ev || bus.o_ovf !== eo || bus.o_val_vld !== 1'b1) begin
            errors++;
            $display("FAIL %s: cycle %0d got upd=%b val=%h ovf=%b vld=%b, expected upd=1 val=%h ovf=%b vld=1",
                     nm, lat, bus.o_val_upd, bus.o_val, bus.o_ovf, bus.o_val_vld, ev, eo);
        end
        step();
        checks++;
        if (bus.o_val_upd !== 1'b0 || bus.o_val_vld !== 1'b1 || bus.o_val !== ev) begin
            errors++;
            $display("FAIL %s hold: got upd=%b vld=%b val=%h, expected upd=0 vld=1 val=%h",
                     nm, bus.o_val_upd, bus.o_val_vld, bus.o_val, ev);
        end
    endtask

    task automatic calc(input int e, input int f, input string nm);
        int lat;
        logic [OW-1:0] v;
        logic o;
        model(e, f, lat, v, o);
        start(e, f);
        watch(lat, v, o, nm);
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if (bus.o_val !== '0 || bus.o_val_vld !== 1'b0 || bus.o_val_upd !== 1'b0 || bus.o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL %s: got val=%h vld=%b upd=%b ovf=%b, expected all 0",
                     nm, bus.o_val, bus.o_val_vld, bus.o_val_upd, bus.o_ovf);
        end
    endtask

    task automatic test_reset();
        bus.i_cal_str = 1'b0;
        bus.i_val     = '0;
        bus.i_frac    = '0;
        rst_n = 1'b0;
        repeat (3) step();
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        check_zero("idle_after_reset");
    endtask

    task automatic test_directed();
        calc(0, 0, "e0_f0");
        calc(5, 8, "e5_f8");
        calc(15, 15, "e15_f15");
        calc(16, 0, "e16_sat");
        calc(31, 0, "e31_sat");
        calc(15, 0, "e15_f0");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            calc(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), "random");
            repeat ($urandom_range(0, 3)) step();
        end
    endtask

    task automatic test_restart();
        bit bad = 0;
        start(10, 0);
        for (int c = 1; c < 4; c++) begin
            if (bus.o_val_upd !== 1'b0 || bus.o_val_vld !== 1'b0) bad = 1;
            step();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL restart: upd or vld high in cycles 1..3");
        end
        start(2, 0);
        watch(4, 16'd4, 1'b0, "restart");
    endtask

    task automatic test_coincident();
        logic [OW-1:0] pv;
        logic po;
        pv = bus.o_val;
        po = bus.o_ovf;
        start(1, 0);
        step();
        start(3, 0);
        checks++;
        if (bus.o_val !== pv || bus.o_ovf !== po) begin
            errors++;
            $display("FAIL coincident_hold: got val=%h ovf=%b, expected val=%h ovf=%b",
                     bus.o_val, bus.o_ovf, pv, po);
        end
        watch(5, 16'd8, 1'b0, "coincident");
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        start(10, 0);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            step();
            if (bus.o_val_upd !== 1'b0 || bus.o_val_vld !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_mid_quiet: upd or vld rose after reset");
        end
        calc(3, 5, "after_reset_mid");
    endtask

    task automatic test_back_to_back();
        calc(7, 3, "b2b_a");
        calc(0, 15, "b2b_b");
        calc(20, 9, "b2b_c");
        calc(14, 15, "b2b_d");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_restart();
        test_coincident();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
